// File: rtl/id_stage_pkg.sv
// Shared widths, opcode field constants, ALU op bit indices and the ds2es bus layout
// for the LA32R decode stage.
package id_stage_pkg;

   localparam int FS2DS_W = 64;
   localparam int DS2ES_W = 148;
   localparam int ALU_OP_W = 12;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   // inst[31:15] for R-type ALU ops and immediate shifts
   localparam logic [16:0] OP17_ADD_W  = 17'h00020;
   localparam logic [16:0] OP17_SUB_W  = 17'h00022;
   localparam logic [16:0] OP17_SLT    = 17'h00024;
   localparam logic [16:0] OP17_SLTU   = 17'h00025;
   localparam logic [16:0] OP17_NOR    = 17'h00028;
   localparam logic [16:0] OP17_AND    = 17'h00029;
   localparam logic [16:0] OP17_OR     = 17'h0002a;
   localparam logic [16:0] OP17_XOR    = 17'h0002b;
   localparam logic [16:0] OP17_SLLI_W = 17'h00081;
   localparam logic [16:0] OP17_SRLI_W = 17'h00089;
   localparam logic [16:0] OP17_SRAI_W = 17'h00091;
   // inst[31:22]
   localparam logic [9:0]  OP10_ADDI_W = 10'h00a;
   localparam logic [9:0]  OP10_LD_W   = 10'h0a2;
   localparam logic [9:0]  OP10_ST_W   = 10'h0a6;
   // inst[31:25]
   localparam logic [6:0]  OP7_LU12I_W = 7'h0a;
   // inst[31:26]
   localparam logic [5:0]  OP6_JIRL    = 6'h13;
   localparam logic [5:0]  OP6_B       = 6'h14;
   localparam logic [5:0]  OP6_BL      = 6'h15;
   localparam logic [5:0]  OP6_BEQ     = 6'h16;
   localparam logic [5:0]  OP6_BNE     = 6'h17;

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic [31:0]         src1;
      logic [31:0]         src2;
      logic                rf_we;
      logic [4:0]          dest;
      logic                mem_we;
      logic                mem_re;
      logic [31:0]         st_data;
      logic [31:0]         pc;
   } ds2es_t;

   // A pending write in EX/MEM blocks a reader of the same non-zero register.
   function automatic logic wtag_hit(input logic [5:0] wtag, input logic [4:0] addr);
      return wtag[5] && (wtag[4:0] == addr) && (addr != 5'd0);
   endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file, two combinational read ports and one write port;
// a same-cycle write is bypassed to matching readers, r0 always reads zero.
module id_stage_regfile (
   input  logic             clk,
   input  logic [1:0][4:0]  raddr,
   output logic [1:0][31:0] rdata,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [31:0]      wdata
);

   logic [31:0] mem [32];

   always_ff @(posedge clk) begin
      if (we && (waddr != 5'd0)) begin
         mem[waddr] <= wdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         assign rdata[gi] = (raddr[gi] == 5'd0)                ? 32'd0 :
                            (we && (waddr == raddr[gi]))       ? wdata :
                                                                 mem[raddr[gi]];
      end
   endgenerate

endmodule

// File: rtl/id_stage.sv
// LA32R decode stage: latches {pc,inst} from fetch, decodes, reads the register file,
// resolves branches, stalls on EX/MEM RAW hazards and drives the packed bus to execute.
module id_stage
   import id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               fs2ds_valid,
   input  logic [FS2DS_W-1:0] fs2ds_bus,
   output logic               ds_allowin,
   output logic [32:0]        br_zip,
   input  logic               es_allowin,
   output logic               ds2es_valid,
   output logic [DS2ES_W-1:0] ds2es_bus,
   input  logic [5:0]         es_wtag,
   input  logic [5:0]         ms_wtag,
   input  logic               ws_rf_we,
   input  logic [4:0]         ws_rf_waddr,
   input  logic [31:0]        ws_rf_wdata
);

   logic        ds_valid_reg;
   logic [31:0] ds_pc_reg;
   logic [31:0] ds_inst_reg;
   logic        ds_ready_go;
   logic        raw_hit;
   logic        br_taken;
   logic [31:0] br_target;

   assign ds_ready_go = ~raw_hit;
   assign ds_allowin  = ~ds_valid_reg | (ds_ready_go & es_allowin);
   assign ds2es_valid = ds_valid_reg & ds_ready_go;

   // br_taken squashes whatever fetch hands over on the same edge (wrong path).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_valid_reg <= 1'b0;
         ds_pc_reg    <= RESET_PC;
         ds_inst_reg  <= 32'd0;
      end else if (ds_allowin) begin
         ds_valid_reg <= fs2ds_valid & ~br_taken;
         ds_pc_reg    <= fs2ds_bus[63:32];
         ds_inst_reg  <= fs2ds_bus[31:0];
      end
   end

   logic [4:0] rd, rj, rk;
   assign rd = ds_inst_reg[4:0];
   assign rj = ds_inst_reg[9:5];
   assign rk = ds_inst_reg[14:10];

   logic [16:0] op17;
   logic [9:0]  op10;
   logic [6:0]  op7;
   logic [5:0]  op6;
   assign op17 = ds_inst_reg[31:15];
   assign op10 = ds_inst_reg[31:22];
   assign op7  = ds_inst_reg[31:25];
   assign op6  = ds_inst_reg[31:26];

   logic inst_add, inst_sub, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
   logic inst_slli, inst_srli, inst_srai, inst_addi, inst_lu12i, inst_ld, inst_st;
   logic inst_beq, inst_bne, inst_b, inst_bl, inst_jirl;
   assign inst_add   = (op17 == OP17_ADD_W);
   assign inst_sub   = (op17 == OP17_SUB_W);
   assign inst_slt   = (op17 == OP17_SLT);
   assign inst_sltu  = (op17 == OP17_SLTU);
   assign inst_and   = (op17 == OP17_AND);
   assign inst_or    = (op17 == OP17_OR);
   assign inst_nor   = (op17 == OP17_NOR);
   assign inst_xor   = (op17 == OP17_XOR);
   assign inst_slli  = (op17 == OP17_SLLI_W);
   assign inst_srli  = (op17 == OP17_SRLI_W);
   assign inst_srai  = (op17 == OP17_SRAI_W);
   assign inst_addi  = (op10 == OP10_ADDI_W);
   assign inst_ld    = (op10 == OP10_LD_W);
   assign inst_st    = (op10 == OP10_ST_W);
   assign inst_lu12i = (op7  == OP7_LU12I_W);
   assign inst_jirl  = (op6  == OP6_JIRL);
   assign inst_b     = (op6  == OP6_B);
   assign inst_bl    = (op6  == OP6_BL);
   assign inst_beq   = (op6  == OP6_BEQ);
   assign inst_bne   = (op6  == OP6_BNE);

   logic alu_r, shift_i, src2_is_imm, r2_is_rd, use_rj, use_r2, gr_we;
   assign alu_r       = inst_add | inst_sub | inst_slt | inst_sltu |
                        inst_and | inst_or | inst_nor | inst_xor;
   assign shift_i     = inst_slli | inst_srli | inst_srai;
   assign src2_is_imm = shift_i | inst_addi | inst_ld | inst_st | inst_lu12i;
   assign r2_is_rd    = inst_st | inst_beq | inst_bne;
   assign use_rj      = alu_r | shift_i | inst_addi | inst_ld | inst_st |
                        inst_beq | inst_bne | inst_jirl;
   assign use_r2      = alu_r | r2_is_rd;
   assign gr_we       = alu_r | shift_i | inst_addi | inst_lu12i | inst_ld | inst_bl | inst_jirl;

   logic [31:0] imm_si12, imm_ui5, imm_si20, offs16, offs26, imm;
   assign imm_si12 = {{20{ds_inst_reg[21]}}, ds_inst_reg[21:10]};
   assign imm_ui5  = {27'd0, ds_inst_reg[14:10]};
   assign imm_si20 = {ds_inst_reg[24:5], 12'd0};
   assign offs16   = {{14{ds_inst_reg[25]}}, ds_inst_reg[25:10], 2'b00};
   assign offs26   = {{4{ds_inst_reg[9]}}, ds_inst_reg[9:0], ds_inst_reg[25:10], 2'b00};
   assign imm      = shift_i ? imm_ui5 : inst_lu12i ? imm_si20 : imm_si12;

   logic [4:0]       raddr2;
   logic [1:0][31:0] rdata;
   logic [31:0]      rj_value, r2_value;
   assign raddr2   = r2_is_rd ? rd : rk;
   assign rj_value = rdata[0];
   assign r2_value = rdata[1];

   id_stage_regfile u_regfile (
      .clk   (clk),
      .raddr ({raddr2, rj}),
      .rdata (rdata),
      .we    (ws_rf_we),
      .waddr (ws_rf_waddr),
      .wdata (ws_rf_wdata)
   );

   assign raw_hit = ds_valid_reg &
                    ((use_rj & (wtag_hit(es_wtag, rj) | wtag_hit(ms_wtag, rj))) |
                     (use_r2 & (wtag_hit(es_wtag, raddr2) | wtag_hit(ms_wtag, raddr2))));

   logic br_cond;
   assign br_cond   = (inst_beq & (rj_value == r2_value)) |
                      (inst_bne & (rj_value != r2_value)) |
                      inst_b | inst_bl | inst_jirl;
   assign br_taken  = ds_valid_reg & ds_ready_go & es_allowin & br_cond;
   assign br_target = inst_jirl ? (rj_value + offs16) :
                      (ds_pc_reg + ((inst_b | inst_bl) ? offs26 : offs16));
   assign br_zip    = {br_taken, br_target};

   ds2es_t ds2es;
   logic   link;
   assign link = inst_bl | inst_jirl;

   always_comb begin
      ds2es                  = '0;
      ds2es.alu_op[ALU_ADD]  = inst_add | inst_addi | inst_ld | inst_st | link;
      ds2es.alu_op[ALU_SUB]  = inst_sub;
      ds2es.alu_op[ALU_SLT]  = inst_slt;
      ds2es.alu_op[ALU_SLTU] = inst_sltu;
      ds2es.alu_op[ALU_AND]  = inst_and;
      ds2es.alu_op[ALU_NOR]  = inst_nor;
      ds2es.alu_op[ALU_OR]   = inst_or;
      ds2es.alu_op[ALU_XOR]  = inst_xor;
      ds2es.alu_op[ALU_SLL]  = inst_slli;
      ds2es.alu_op[ALU_SRL]  = inst_srli;
      ds2es.alu_op[ALU_SRA]  = inst_srai;
      ds2es.alu_op[ALU_LUI]  = inst_lu12i;
      ds2es.src1             = link ? ds_pc_reg : rj_value;
      ds2es.src2             = link ? 32'd4 : src2_is_imm ? imm : r2_value;
      ds2es.dest             = inst_bl ? 5'd1 : rd;
      ds2es.rf_we            = gr_we & (ds2es.dest != 5'd0);
      ds2es.mem_we           = inst_st;
      ds2es.mem_re           = inst_ld;
      ds2es.st_data          = r2_value;
      ds2es.pc               = ds_pc_reg;
   end

   assign ds2es_bus = ds2es;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, RAW stall/release, branch squash, link, stall-held jirl,
// store, undefined encoding and asynchronous mid-operation reset.
module tb_id_stage;

   logic         clk = 1'b0;
   logic         resetn;
   logic         fs2ds_valid;
   logic [63:0]  fs2ds_bus;
   logic         ds_allowin;
   logic [32:0]  br_zip;
   logic         es_allowin;
   logic         ds2es_valid;
   logic [147:0] ds2es_bus;
   logic [5:0]   es_wtag;
   logic [5:0]   ms_wtag;
   logic         ws_rf_we;
   logic [4:0]   ws_rf_waddr;
   logic [31:0]  ws_rf_wdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk         (clk),
      .resetn      (resetn),
      .fs2ds_valid (fs2ds_valid),
      .fs2ds_bus   (fs2ds_bus),
      .ds_allowin  (ds_allowin),
      .br_zip      (br_zip),
      .es_allowin  (es_allowin),
      .ds2es_valid (ds2es_valid),
      .ds2es_bus   (ds2es_bus),
      .es_wtag     (es_wtag),
      .ms_wtag     (ms_wtag),
      .ws_rf_we    (ws_rf_we),
      .ws_rf_waddr (ws_rf_waddr),
      .ws_rf_wdata (ws_rf_wdata)
   );

   logic [11:0] b_alu;
   logic [31:0] b_src1, b_src2, b_st, b_pc;
   logic        b_rf_we, b_mem_we, b_mem_re;
   logic [4:0]  b_dest;
   assign b_alu    = ds2es_bus[147:136];
   assign b_src1   = ds2es_bus[135:104];
   assign b_src2   = ds2es_bus[103:72];
   assign b_rf_we  = ds2es_bus[71];
   assign b_dest   = ds2es_bus[70:66];
   assign b_mem_we = ds2es_bus[65];
   assign b_mem_re = ds2es_bus[64];
   assign b_st     = ds2es_bus[63:32];
   assign b_pc     = ds2es_bus[31:0];

   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rj, input logic [11:0] si12);
      return {10'b0000001010, si12, rj, rd};
   endfunction
   function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk);
      return {17'b00000000000100000, rk, rj, rd};
   endfunction
   function automatic logic [31:0] enc_st(input logic [4:0] rd, input logic [4:0] rj, input logic [11:0] si12);
      return {10'b0010100110, si12, rj, rd};
   endfunction
   function automatic logic [31:0] enc_beq(input logic [4:0] rj, input logic [4:0] rd, input logic [15:0] o16);
      return {6'b010110, o16, rj, rd};
   endfunction
   function automatic logic [31:0] enc_jirl(input logic [4:0] rd, input logic [4:0] rj, input logic [15:0] o16);
      return {6'b010011, o16, rj, rd};
   endfunction
   function automatic logic [31:0] enc_b26(input logic [5:0] op, input logic [25:0] o26);
      return {op, o26[15:0], o26[25:16]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; fs2ds_valid = 1'b0; fs2ds_bus = '0; es_allowin = 1'b1;
      es_wtag = '0; ms_wtag = '0; ws_rf_we = 1'b0; ws_rf_waddr = '0; ws_rf_wdata = '0;
      tick(); tick();
      n_cmp++; if (ds2es_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ds2es_valid); end
      n_cmp++; if (br_zip !== 33'd0 && br_zip[32] !== 1'b0) begin n_err++; $display("FAIL reset_br: got %h want taken=0", br_zip); end
      n_cmp++; if (ds_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b want 1", ds_allowin); end
      n_cmp++; if (b_pc !== 32'h1c000000) begin n_err++; $display("FAIL reset_pc: got %h want 1c000000", b_pc); end
      resetn = 1'b1;
      tick();
      $display("test_reset: %0d compared", n_cmp);
   endtask

   task automatic test_raw();
      fs2ds_valid = 1'b1; fs2ds_bus = {32'h1c000000, enc_addi(5'd2, 5'd0, 12'd5)};
      tick();
      n_cmp++; if (ds2es_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", ds2es_valid); end
      n_cmp++; if (b_src2 !== 32'd5) begin n_err++; $display("FAIL addi_src2: got %h want 5", b_src2); end
      n_cmp++; if (b_dest !== 5'd2 || b_rf_we !== 1'b1) begin n_err++; $display("FAIL addi_dest: got we=%b d=%0d want we=1 d=2", b_rf_we, b_dest); end
      n_cmp++; if (b_alu !== 12'h001) begin n_err++; $display("FAIL addi_alu: got %h want 001", b_alu); end
      fs2ds_bus = {32'h1c000004, enc_add(5'd3, 5'd2, 5'd2)};
      tick();
      es_wtag = 6'h22; fs2ds_bus = {32'h1c000008, 32'hffffffff}; #1;
      n_cmp++; if (ds2es_valid !== 1'b0) begin n_err++; $display("FAIL raw_es_valid: got %b want 0", ds2es_valid); end
      n_cmp++; if (ds_allowin !== 1'b0) begin n_err++; $display("FAIL raw_es_allowin: got %b want 0", ds_allowin); end
      tick();
      es_wtag = 6'h00; ms_wtag = 6'h22; #1;
      n_cmp++; if (ds2es_valid !== 1'b0) begin n_err++; $display("FAIL raw_ms_valid: got %b want 0", ds2es_valid); end
      n_cmp++; if (b_pc !== 32'h1c000004) begin n_err++; $display("FAIL raw_held_pc: got %h want 1c000004", b_pc); end
      tick();
      ms_wtag = 6'h00; ws_rf_we = 1'b1; ws_rf_waddr = 5'd2; ws_rf_wdata = 32'd5; fs2ds_valid = 1'b0; #1;
      n_cmp++; if (ds2es_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid: got %b want 1", ds2es_valid); end
      n_cmp++; if (b_src1 !== 32'd5 || b_src2 !== 32'd5) begin n_err++; $display("FAIL rel_src: got %h/%h want 5/5", b_src1, b_src2); end
      n_cmp++; if (b_dest !== 5'd3) begin n_err++; $display("FAIL rel_dest: got %0d want 3", b_dest); end
      tick();
      ws_rf_we = 1'b0;
      $display("test_raw: %0d compared", n_cmp);
   endtask

   task automatic test_branch();
      ws_rf_we = 1'b1; ws_rf_waddr = 5'd1; ws_rf_wdata = 32'h55;
      fs2ds_valid = 1'b1; fs2ds_bus = {32'h1c000000, enc_beq(5'd1, 5'd1, 16'd4)};
      tick();
      ws_rf_we = 1'b0; #1;
      n_cmp++; if (br_zip !== {1'b1, 32'h1c000010}) begin n_err++; $display("FAIL beq_zip: got %h want 11c000010", br_zip); end
      fs2ds_bus = {32'h1c000004, enc_addi(5'd4, 5'd0, 12'd7)};
      tick();
      n_cmp++; if (ds2es_valid !== 1'b0) begin n_err++; $display("FAIL beq_squash: got %b want 0", ds2es_valid); end
      n_cmp++; if (br_zip[32] !== 1'b0) begin n_err++; $display("FAIL beq_pulse: got %b want 0", br_zip[32]); end
      fs2ds_bus = {32'h1c000020, enc_b26(6'b010101, 26'h40)};
      tick();
      n_cmp++; if (b_rf_we !== 1'b1 || b_dest !== 5'd1) begin n_err++; $display("FAIL bl_dest: got we=%b d=%0d want we=1 d=1", b_rf_we, b_dest); end
      n_cmp++; if (b_src1 !== 32'h1c000020 || b_src2 !== 32'd4) begin n_err++; $display("FAIL bl_src: got %h/%h want 1c000020/4", b_src1, b_src2); end
      n_cmp++; if (br_zip !== {1'b1, 32'h1c000120}) begin n_err++; $display("FAIL bl_zip: got %h want 11c000120", br_zip); end
      fs2ds_valid = 1'b0;
      tick();
      $display("test_branch: %0d compared", n_cmp);
   endtask

   task automatic test_jirl_stall();
      es_allowin = 1'b0; fs2ds_valid = 1'b1; fs2ds_bus = {32'h1c000040, enc_jirl(5'd5, 5'd1, 16'd2)};
      tick();
      n_cmp++; if (br_zip[32] !== 1'b0) begin n_err++; $display("FAIL jirl_hold_br: got %b want 0", br_zip[32]); end
      n_cmp++; if (ds2es_valid !== 1'b1 || ds_allowin !== 1'b0) begin n_err++; $display("FAIL jirl_hold_hs: got v=%b a=%b want v=1 a=0", ds2es_valid, ds_allowin); end
      fs2ds_bus = {32'h1c000044, 32'hffffffff};
      tick();
      n_cmp++; if (br_zip[32] !== 1'b0) begin n_err++; $display("FAIL jirl_hold2_br: got %b want 0", br_zip[32]); end
      n_cmp++; if (b_pc !== 32'h1c000040 || b_src1 !== 32'h1c000040 || b_src2 !== 32'd4 || b_dest !== 5'd5)
         begin n_err++; $display("FAIL jirl_stable: got pc=%h s1=%h s2=%h d=%0d want 1c000040/1c000040/4/5", b_pc, b_src1, b_src2, b_dest); end
      es_allowin = 1'b1; #1;
      n_cmp++; if (br_zip !== {1'b1, 32'h5d}) begin n_err++; $display("FAIL jirl_zip: got %h want 10000005d", br_zip); end
      tick();
      n_cmp++; if (br_zip[32] !== 1'b0 || ds2es_valid !== 1'b0) begin n_err++; $display("FAIL jirl_after: got br=%b v=%b want 0/0", br_zip[32], ds2es_valid); end
      fs2ds_valid = 1'b0;
      tick();
      $display("test_jirl_stall: %0d compared", n_cmp);
   endtask

   task automatic test_store_undef();
      fs2ds_valid = 1'b1; fs2ds_bus = {32'h1c000050, enc_st(5'd1, 5'd0, 12'hffc)};
      tick();
      n_cmp++; if (b_mem_we !== 1'b1 || b_mem_re !== 1'b0 || b_rf_we !== 1'b0) begin n_err++; $display("FAIL st_ctl: got we=%b re=%b rf=%b want 1/0/0", b_mem_we, b_mem_re, b_rf_we); end
      n_cmp++; if (b_st !== 32'h55 || b_src2 !== 32'hfffffffc) begin n_err++; $display("FAIL st_data: got %h/%h want 55/fffffffc", b_st, b_src2); end
      fs2ds_bus = {32'h1c000060, 32'hffffffff};
      tick();
      n_cmp++; if (ds2es_valid !== 1'b1) begin n_err++; $display("FAIL undef_valid: got %b want 1", ds2es_valid); end
      n_cmp++; if (b_rf_we !== 1'b0 || b_mem_we !== 1'b0 || b_mem_re !== 1'b0 || br_zip[32] !== 1'b0)
         begin n_err++; $display("FAIL undef_ctl: got rf=%b we=%b re=%b br=%b want 0000", b_rf_we, b_mem_we, b_mem_re, br_zip[32]); end
      fs2ds_valid = 1'b0;
      tick();
      $display("test_store_undef: %0d compared", n_cmp);
   endtask

   task automatic test_async_reset();
      fs2ds_valid = 1'b1; fs2ds_bus = {32'h1c000070, enc_b26(6'b010100, 26'd2)};
      tick();
      fs2ds_valid = 1'b0;
      n_cmp++; if (br_zip !== {1'b1, 32'h1c000078} || ds2es_valid !== 1'b1) begin n_err++; $display("FAIL b_zip: got %h v=%b want 11c000078 v=1", br_zip, ds2es_valid); end
      #2 resetn = 1'b0;
      #1;
      n_cmp++; if (ds2es_valid !== 1'b0 || br_zip[32] !== 1'b0) begin n_err++; $display("FAIL arst_out: got v=%b br=%b want 0/0", ds2es_valid, br_zip[32]); end
      n_cmp++; if (ds_allowin !== 1'b1 || b_pc !== 32'h1c000000) begin n_err++; $display("FAIL arst_state: got a=%b pc=%h want 1/1c000000", ds_allowin, b_pc); end
      tick();
      resetn = 1'b1;
      tick();
      $display("test_async_reset: %0d compared", n_cmp);
   endtask

   initial begin
      test_reset();
      test_raw();
      test_branch();
      test_jirl_stall();
      test_store_undef();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
